inst_fetcher: RTL and testbench

Front-end fetch stage that sits directly downstream of the ROB broadcast bus. It consumes the flush/redirect pair (reset and PC) that the bus forwards from the reorder buffer. It issues word fetches to the memory controller, one outstanding at a time, and buffers returned instructions with their PCs in a small FIFO. The issuer drains that FIFO through a valid/ready handshake.

---
 rtl/inst_fetcher.sv | 144 ++++++++++++++
 tb/tb_inst_fetcher.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetcher.sv
// Instruction fetch stage: one outstanding word fetch, small instruction FIFO toward the issuer.
// Optional JAL predecode (next-PC redirect and taken flag) is enabled with `define PREDECODE_JAL_EN.
module inst_fetcher #(
  parameter int unsigned QUEUE_WIDTH = 2,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        reset_from_rob_bus,
  input  logic [31:0] pc_from_rob_bus,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        inst_valid_to_issuer,
  output logic [31:0] inst_to_issuer,
  output logic [31:0] pc_to_issuer,
  output logic        jump_to_issuer,
  input  logic        ready_from_issuer
);

  localparam int unsigned DEPTH = 1 << QUEUE_WIDTH;
  localparam int unsigned CW    = QUEUE_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} state_t;

  state_t                 state;
  logic [31:0]            fetch_pc;
  logic [QUEUE_WIDTH-1:0] head;
  logic [QUEUE_WIDTH-1:0] tail;
  logic [CW-1:0]          count;

  logic [31:0] q_inst [DEPTH];
  logic [31:0] q_pc   [DEPTH];
  logic        q_jump [DEPTH];

  logic        flush;
  logic        push;
  logic        pop;
  logic        is_jal;
  logic [31:0] next_pc;

  // A flush overrides every same-cycle push and pop.
  assign flush = rdy_in && reset_from_rob_bus;
  assign push  = rdy_in && !reset_from_rob_bus && (state == WAIT) && mem_resp_valid;
  assign pop   = rdy_in && !reset_from_rob_bus && inst_valid_to_issuer && ready_from_issuer;

`ifdef PREDECODE_JAL_EN
  logic [31:0] jal_imm;
  assign is_jal  = (mem_resp_data[6:0] == 7'b1101111);
  assign jal_imm = {{11{mem_resp_data[31]}}, mem_resp_data[31], mem_resp_data[19:12],
                    mem_resp_data[20], mem_resp_data[30:21], 1'b0};
  assign next_pc = is_jal ? (fetch_pc + jal_imm) : (fetch_pc + 32'd4);
`else
  assign is_jal  = 1'b0;
  assign next_pc = fetch_pc + 32'd4;
`endif

  // Head entry presented combinationally; zero when the queue is empty.
  assign inst_valid_to_issuer = (count != '0);
  assign inst_to_issuer       = inst_valid_to_issuer ? q_inst[head] : 32'h0;
  assign pc_to_issuer         = inst_valid_to_issuer ? q_pc[head]   : 32'h0;
  assign jump_to_issuer       = inst_valid_to_issuer ? q_jump[head] : 1'b0;

  always_ff @(posedge clk_in) begin
    if (push) begin
      q_inst[tail] <= mem_resp_data;
      q_pc[tail]   <= fetch_pc;
      q_jump[tail] <= is_jal;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + QUEUE_WIDTH'(1);
      if (pop)  head <= head + QUEUE_WIDTH'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Fetch FSM; a response for a request accepted before a flush is drained in DISCARD.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= IDLE;
      fetch_pc      <= RESET_PC;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= RESET_PC;
    end else if (rdy_in) begin
      if (reset_from_rob_bus) begin
        fetch_pc      <= pc_from_rob_bus;
        mem_req_valid <= 1'b0;
        unique case (state)
          IDLE:    state <= IDLE;
          REQ:     state <= mem_req_ready  ? DISCARD : IDLE;
          WAIT:    state <= mem_resp_valid ? IDLE : DISCARD;
          DISCARD: state <= mem_resp_valid ? IDLE : DISCARD;
          default: state <= IDLE;
        endcase
      end else begin
        unique case (state)
          IDLE: begin
            if (count < CW'(DEPTH)) begin
              state         <= REQ;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= fetch_pc;
            end
          end
          REQ: begin
            if (mem_req_ready) begin
              state         <= WAIT;
              mem_req_valid <= 1'b0;
            end
          end
          WAIT: begin
            if (mem_resp_valid) begin
              state    <= IDLE;
              fetch_pc <= next_pc;
            end
          end
          DISCARD: begin
            if (mem_resp_valid) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetcher.sv
// Randomized scoreboard bench for inst_fetcher: memory model, issuer model and a PC-stream reference.
module tb_inst_fetcher;

  localparam int unsigned DEPTH = 4;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        reset_from_rob_bus = 1'b0;
  logic [31:0] pc_from_rob_bus = 32'h0;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b0;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = 32'h0;
  logic        inst_valid_to_issuer;
  logic [31:0] inst_to_issuer;
  logic [31:0] pc_to_issuer;
  logic        jump_to_issuer;
  logic        ready_from_issuer = 1'b0;

  inst_fetcher #(.QUEUE_WIDTH(2), .RESET_PC(32'h0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .reset_from_rob_bus(reset_from_rob_bus), .pc_from_rob_bus(pc_from_rob_bus),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .inst_valid_to_issuer(inst_valid_to_issuer), .inst_to_issuer(inst_to_issuer),
    .pc_to_issuer(pc_to_issuer), .jump_to_issuer(jump_to_issuer),
    .ready_from_issuer(ready_from_issuer)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        jump;
  } ent_t;

  ent_t        exp_q[$];
  logic [31:0] ref_pc = 32'h0;
  bit          live = 1'b0;
  int          checks = 0;
  int          passes = 0;
  int          n_pops = 0;

  // Stimulus knobs (percentages) and memory contents mode.
  int k_mready = 100, k_iready = 0, k_flush = 0, k_rdy = 100, k_lat = 1;
  bit nop_mode = 1'b1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [31:0] hash(input logic [31:0] a);
    logic [31:0] h;
    h = (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    return h ^ (h >> 15);
  endfunction

  function automatic bit is_jal_at(input logic [31:0] a);
    logic [31:0] h;
    h = hash(a);
    if (nop_mode) return a == 32'h20;
    return h[3:0] == 4'h0;
  endfunction

  function automatic logic [31:0] jal_off(input logic [31:0] a);
    logic [31:0] h;
    logic [6:0]  o;
    h = hash(a);
    o = {h[9:5], 2'b00};
    if (nop_mode) return 32'd16;
    return {{25{o[6]}}, o};
  endfunction

  // Memory image: mostly arbitrary non-JAL words, with JALs at known offsets.
  function automatic logic [31:0] inst_at(input logic [31:0] a);
    logic [31:0] h;
    logic [31:0] off;
    h = hash(a);
    if (is_jal_at(a)) begin
      off = jal_off(a);
      return {off[20], off[10:1], off[11], off[19:12], 5'd0, 7'b1101111};
    end
    if (nop_mode) return 32'h00000013;
    return {h[31:7], (h[6:0] == 7'b1101111) ? 7'h13 : h[6:0]};
  endfunction

  function automatic bit pct(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  // Monitor / reference model: judges the events of the upcoming rising edge.
  initial begin
    ent_t e;
    bit   jmp;
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        exp_q.delete();
        ref_pc = 32'h0;
        live   = 1'b0;
      end else begin
        chk("inst_valid", 32'(inst_valid_to_issuer), 32'(exp_q.size() != 0));
        if (rdy_in) begin
          if (reset_from_rob_bus) begin
            exp_q.delete();
            ref_pc = pc_from_rob_bus;
            live   = 1'b0;
          end else begin
            if (mem_req_valid && mem_req_ready) begin
              chk("req_addr", mem_req_addr, ref_pc);
              chk("credit", 32'(exp_q.size() < DEPTH), 32'd1);
              live = 1'b1;
            end
            if (inst_valid_to_issuer && ready_from_issuer && exp_q.size() != 0) begin
              e = exp_q.pop_front();
              chk("head_pc", pc_to_issuer, e.pc);
              chk("head_inst", inst_to_issuer, e.inst);
              chk("head_jump", 32'(jump_to_issuer), 32'(e.jump));
              n_pops++;
            end
            if (mem_resp_valid && live) begin
`ifdef PREDECODE_JAL_EN
              jmp = is_jal_at(ref_pc);
`else
              jmp = 1'b0;
`endif
              exp_q.push_back('{inst: inst_at(ref_pc), pc: ref_pc, jump: jmp});
              ref_pc = jmp ? ref_pc + jal_off(ref_pc) : ref_pc + 32'd4;
              live   = 1'b0;
            end
          end
        end
      end
    end
  end

  // Memory controller model state.
  bit          pend = 1'b0;
  bit          resp_out = 1'b0;
  int          lat = 0;
  logic [31:0] paddr = 32'h0;

  task automatic cycle();
    @(negedge clk_in);
    if (rst_in) begin
      pend     = 1'b0;
      resp_out = 1'b0;
    end else if (rdy_in) begin
      if (mem_resp_valid) resp_out = 1'b0;
      if (mem_req_valid && mem_req_ready) begin
        pend  = 1'b1;
        paddr = mem_req_addr;
        lat   = $urandom_range(1, k_lat);
      end
    end
    @(posedge clk_in);
    #1;
    if (pend) begin
      if (lat <= 1) begin
        pend          = 1'b0;
        resp_out      = 1'b1;
        mem_resp_data = inst_at(paddr);
      end else lat--;
    end
    mem_resp_valid     = resp_out;
    mem_req_ready      = pct(k_mready);
    ready_from_issuer  = pct(k_iready);
    rdy_in             = pct(k_rdy);
    reset_from_rob_bus = pct(k_flush);
    pc_from_rob_bus    = 32'($urandom_range(0, 255)) << 2;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst_in = 1'b1;
    run(3);
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid_to_issuer), 32'd0);
    chk("rst_inst", inst_to_issuer, 32'h0);
    chk("rst_pc", pc_to_issuer, 32'h0);
    chk("rst_jump", 32'(jump_to_issuer), 32'd0);
    rst_in = 1'b0;

    // Issuer stalled: queue fills to four entries, then requests stop.
    run(40);
    chk("full_req_valid", 32'(mem_req_valid), 32'd0);
    chk("full_head_pc", pc_to_issuer, 32'h0);
    chk("full_count", 32'(exp_q.size()), 32'd4);

    // Drain and fetch past the JAL at 0x20.
    k_iready = 100;
    run(80);

    // Mid-run reset, then randomized traffic with flushes and stalls.
    rst_in = 1'b1;
    run(2);
    nop_mode = 1'b0;
    rst_in   = 1'b0;
    for (int p = 0; p < 12; p++) begin
      k_mready = $urandom_range(30, 100);
      k_iready = $urandom_range(0, 100);
      k_flush  = $urandom_range(0, 8);
      k_rdy    = $urandom_range(60, 100);
      k_lat    = $urandom_range(1, 4);
      run(250);
    end

    k_mready = 100; k_iready = 100; k_flush = 0; k_rdy = 100; k_lat = 1;
    run(100);
    chk("progress", 32'(n_pops > 200), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
